// File: rtl/inst_issue_ctrl_if.sv
// Bundles the fetch, decode, issue, JALR-resolve and flush signals of the
// instruction issue controller.
//   master : the issue controller (drives fetch requests, decoder input, issue fields)
//   slave  : its environment (icache, decoder, ROB/RS/LSB status, redirect sources)
interface inst_issue_ctrl_if;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_inst;

  logic [31:0] dec_inst;
  logic [5:0]  dec_order;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm;

  logic        rob_full;
  logic        rs_full;
  logic        lsb_full;

  logic        issue_valid;
  logic [5:0]  issue_order;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [31:0] issue_imm;
  logic [31:0] issue_pc;
  logic        issue_to_lsb;
  logic        issue_pred_taken;

  logic        jalr_done_valid;
  logic [31:0] jalr_done_pc;
  logic        flush_valid;
  logic [31:0] flush_pc;

  modport master (
    output ic_req_valid, ic_req_addr, dec_inst,
           issue_valid, issue_order, issue_rd, issue_rs1, issue_rs2,
           issue_imm, issue_pc, issue_to_lsb, issue_pred_taken,
    input  ic_resp_valid, ic_resp_inst,
           dec_order, dec_rd, dec_rs1, dec_rs2, dec_imm,
           rob_full, rs_full, lsb_full,
           jalr_done_valid, jalr_done_pc, flush_valid, flush_pc
  );

  modport slave (
    input  ic_req_valid, ic_req_addr, dec_inst,
           issue_valid, issue_order, issue_rd, issue_rs1, issue_rs2,
           issue_imm, issue_pc, issue_to_lsb, issue_pred_taken,
    output ic_resp_valid, ic_resp_inst,
           dec_order, dec_rd, dec_rs1, dec_rs2, dec_imm,
           rob_full, rs_full, lsb_full,
           jalr_done_valid, jalr_done_pc, flush_valid, flush_pc
  );
endinterface

// File: rtl/inst_issue_ctrl.sv
// Front-end sequencer: fetches one instruction at pc from the icache, feeds
// it to the external combinational decoder, issues the decoded fields to the
// ROB and RS/LSB when they can accept, and predicts the next pc (JAL taken,
// backward branches taken, stall on JALR until its target resolves).
// Ports:
//   clk_in    system clock, rising edge
//   rst_n_in  asynchronous active-low reset
//   rdy_in    global ready; low freezes the block (valid outputs drop to 0)
//   bus       inst_issue_ctrl_if.master: icache req/resp, decoder, full
//             flags, issue fields, JALR resolve, ROB flush
module inst_issue_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  inst_issue_ctrl_if.master     bus
);

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    ISSUE,
    STALL_JALR,
    DROP
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] ibuf, ibuf_n;
  logic        req_n;
  logic        fire;

  logic is_lsb, is_jal, is_jalr, is_br, pred;

  always_comb begin
    is_lsb  = ((bus.dec_order >= 6'd13) && (bus.dec_order <= 6'd17)) ||
              ((bus.dec_order >= 6'd27) && (bus.dec_order <= 6'd29));
    is_jal  = (bus.dec_order == 6'd30);
    is_jalr = (bus.dec_order == 6'd12);
    is_br   = (bus.dec_order >= 6'd31) && (bus.dec_order <= 6'd36);
    pred    = is_jal || (is_br && bus.dec_imm[31]);
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ibuf_n  = ibuf;
    req_n   = 1'b0;
    fire    = 1'b0;
    if (bus.flush_valid) begin
      // A response still owed by the icache must be swallowed in DROP.
      pc_n = bus.flush_pc;
      if (state == DROP)
        state_n = bus.ic_resp_valid ? FETCH : DROP;
      else if (state == WAIT && !bus.ic_resp_valid)
        state_n = DROP;
      else
        state_n = FETCH;
    end else begin
      case (state)
        FETCH: begin
          req_n   = 1'b1;
          state_n = WAIT;
        end
        WAIT: begin
          if (bus.ic_resp_valid) begin
            ibuf_n  = bus.ic_resp_inst;
            state_n = ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.rob_full && !(is_lsb ? bus.lsb_full : bus.rs_full)) begin
            fire = 1'b1;
            if (pred)         pc_n = pc + bus.dec_imm;
            else if (is_jalr) pc_n = pc;
            else              pc_n = pc + 32'd4;
            state_n = is_jalr ? STALL_JALR : FETCH;
          end
        end
        STALL_JALR: begin
          if (bus.jalr_done_valid) begin
            pc_n    = bus.jalr_done_pc;
            state_n = FETCH;
          end
        end
        DROP: begin
          if (bus.ic_resp_valid) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                <= FETCH;
      pc                   <= RESET_PC;
      ibuf                 <= '0;
      bus.ic_req_valid     <= 1'b0;
      bus.ic_req_addr      <= RESET_PC;
      bus.issue_valid      <= 1'b0;
      bus.issue_order      <= '0;
      bus.issue_rd         <= '0;
      bus.issue_rs1        <= '0;
      bus.issue_rs2        <= '0;
      bus.issue_imm        <= '0;
      bus.issue_pc         <= '0;
      bus.issue_to_lsb     <= 1'b0;
      bus.issue_pred_taken <= 1'b0;
    end else if (rdy_in) begin
      state            <= state_n;
      pc               <= pc_n;
      ibuf             <= ibuf_n;
      bus.ic_req_valid <= req_n;
      bus.issue_valid  <= fire;
      if (req_n) bus.ic_req_addr <= pc;
      if (fire) begin
        bus.issue_order      <= bus.dec_order;
        bus.issue_rd         <= bus.dec_rd;
        bus.issue_rs1        <= bus.dec_rs1;
        bus.issue_rs2        <= bus.dec_rs2;
        bus.issue_imm        <= bus.dec_imm;
        bus.issue_pc         <= pc;
        bus.issue_to_lsb     <= is_lsb;
        bus.issue_pred_taken <= pred;
      end
    end else begin
      bus.ic_req_valid <= 1'b0;
      bus.issue_valid  <= 1'b0;
    end
  end

  assign bus.dec_inst = ibuf;

endmodule

// File: tb/tb_inst_issue_ctrl.sv
module tb_inst_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  inst_issue_ctrl_if bus ();

  inst_issue_ctrl #(.RESET_PC(32'h0)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Advance one cycle; leave the bench 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ic_req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic set_dec(input logic [5:0] order, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    bus.dec_order = order;
    bus.dec_rd    = rd;
    bus.dec_rs1   = rs1;
    bus.dec_rs2   = rs2;
    bus.dec_imm   = imm;
  endtask

  // Return an instruction d cycles after the request was first seen.
  task automatic respond(input logic [31:0] inst, input int d);
    for (int i = 0; i < d; i++) tick();
    bus.ic_resp_valid = 1'b1;
    bus.ic_resp_inst  = inst;
    tick();
    bus.ic_resp_valid = 1'b0;
  endtask

  // From a freshly seen request: flush, drop the stale response, refetch at a.
  task automatic goto_pc(input logic [31:0] a);
    bus.flush_valid = 1'b1;
    bus.flush_pc    = a;
    tick();
    bus.flush_valid = 1'b0;
    bus.ic_resp_valid = 1'b1;
    bus.ic_resp_inst  = 32'h00000013;
    tick();
    bus.ic_resp_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bit ok;
    #2;
    vectors++; if (bus.ic_req_valid !== 1'b0 || bus.issue_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valids got req=%b iss=%b want 0 0", bus.ic_req_valid, bus.issue_valid); end
    vectors++; if (bus.ic_req_addr !== 32'h0 || bus.dec_inst !== 32'h0) begin
      miscompares++; $display("FAIL reset_addr got addr=%h inst=%h want 0 0", bus.ic_req_addr, bus.dec_inst); end
    vectors++; if (bus.issue_order !== 6'd0 || bus.issue_imm !== 32'h0 || bus.issue_pc !== 32'h0 ||
                   bus.issue_to_lsb !== 1'b0 || bus.issue_pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL reset_fields got order=%0d imm=%h pc=%h want zeros", bus.issue_order, bus.issue_imm, bus.issue_pc); end
    tick(); tick();
    rst_n = 1'b1;
    wait_req(ok);
    vectors++; if (!ok || bus.ic_req_addr !== 32'h0) begin
      miscompares++; $display("FAIL reset_first_fetch got ok=%b addr=%h want 1 00000000", ok, bus.ic_req_addr); end
  endtask

  task automatic test_basic();
    set_dec(6'd18, 5'd1, 5'd0, 5'd5, 32'd5);
    respond(32'h00500093, 2);
    vectors++; if (bus.issue_valid !== 1'b0 || bus.dec_inst !== 32'h00500093) begin
      miscompares++; $display("FAIL basic_ibuf got iss=%b inst=%h want 0 00500093", bus.issue_valid, bus.dec_inst); end
    tick();
    vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_order !== 6'd18 || bus.issue_rd !== 5'd1 ||
                   bus.issue_imm !== 32'd5 || bus.issue_pc !== 32'h0 || bus.issue_to_lsb !== 1'b0 ||
                   bus.issue_pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL basic_issue got v=%b ord=%0d rd=%0d imm=%h pc=%h lsb=%b pt=%b want 1 18 1 5 0 0 0",
        bus.issue_valid, bus.issue_order, bus.issue_rd, bus.issue_imm, bus.issue_pc, bus.issue_to_lsb, bus.issue_pred_taken); end
    tick();
    vectors++; if (bus.issue_valid !== 1'b0 || bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h4) begin
      miscompares++; $display("FAIL basic_next got iss=%b req=%b addr=%h want 0 1 00000004", bus.issue_valid, bus.ic_req_valid, bus.ic_req_addr); end
  endtask

  task automatic test_rdy_freeze();
    set_dec(6'd18, 5'd3, 5'd0, 5'd0, 32'd1);
    respond(32'h00100193, 1);
    rdy = 1'b0;
    tick(); tick();
    vectors++; if (bus.issue_valid !== 1'b0 || bus.ic_req_valid !== 1'b0) begin
      miscompares++; $display("FAIL rdy_freeze got iss=%b req=%b want 0 0", bus.issue_valid, bus.ic_req_valid); end
    rdy = 1'b1;
    tick();
    vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 32'h4 || bus.issue_rd !== 5'd3) begin
      miscompares++; $display("FAIL rdy_resume got iss=%b pc=%h rd=%0d want 1 00000004 3", bus.issue_valid, bus.issue_pc, bus.issue_rd); end
    tick();
    vectors++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h8) begin
      miscompares++; $display("FAIL rdy_next got req=%b addr=%h want 1 00000008", bus.ic_req_valid, bus.ic_req_addr); end
  endtask

  task automatic test_jal();
    goto_pc(32'h10);
    set_dec(6'd30, 5'd0, 5'd0, 5'd0, 32'hfffffff8);
    respond(32'hff9ff06f, 1);
    tick();
    vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_pred_taken !== 1'b1 || bus.issue_pc !== 32'h10) begin
      miscompares++; $display("FAIL jal_issue got v=%b pt=%b pc=%h want 1 1 00000010", bus.issue_valid, bus.issue_pred_taken, bus.issue_pc); end
    tick();
    vectors++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h8) begin
      miscompares++; $display("FAIL jal_target got req=%b addr=%h want 1 00000008", bus.ic_req_valid, bus.ic_req_addr); end
  endtask

  task automatic test_branch();
    goto_pc(32'h20);
    set_dec(6'd31, 5'd0, 5'd0, 5'd0, 32'hfffffffc);
    respond(32'hfe000ee3, 1);
    tick();
    vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_pred_taken !== 1'b1 || bus.issue_to_lsb !== 1'b0) begin
      miscompares++; $display("FAIL br_back_issue got v=%b pt=%b lsb=%b want 1 1 0", bus.issue_valid, bus.issue_pred_taken, bus.issue_to_lsb); end
    tick();
    vectors++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h1c) begin
      miscompares++; $display("FAIL br_back_target got req=%b addr=%h want 1 0000001c", bus.ic_req_valid, bus.ic_req_addr); end
    goto_pc(32'h20);
    set_dec(6'd31, 5'd0, 5'd0, 5'd0, 32'd8);
    respond(32'h00000463, 1);
    tick();
    vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_pred_taken !== 1'b0) begin
      miscompares++; $display("FAIL br_fwd_issue got v=%b pt=%b want 1 0", bus.issue_valid, bus.issue_pred_taken); end
    tick();
    vectors++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h24) begin
      miscompares++; $display("FAIL br_fwd_target got req=%b addr=%h want 1 00000024", bus.ic_req_valid, bus.ic_req_addr); end
  endtask

  task automatic test_lsb_full();
    int pulses;
    bus.lsb_full = 1'b1;
    bus.rs_full  = 1'b1;
    set_dec(6'd15, 5'd2, 5'd1, 5'd0, 32'd0);
    respond(32'h0000a103, 1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.issue_valid === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin
      miscompares++; $display("FAIL lsb_full_block got %0d issues want 0", pulses); end
    bus.lsb_full = 1'b0;
    tick();
    vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_to_lsb !== 1'b1 || bus.issue_rd !== 5'd2 ||
                   bus.issue_rs1 !== 5'd1 || bus.issue_pc !== 32'h24) begin
      miscompares++; $display("FAIL lsb_release got v=%b lsb=%b rd=%0d rs1=%0d pc=%h want 1 1 2 1 00000024",
        bus.issue_valid, bus.issue_to_lsb, bus.issue_rd, bus.issue_rs1, bus.issue_pc); end
    tick();
    vectors++; if (bus.issue_valid !== 1'b0 || bus.ic_req_addr !== 32'h28 || bus.ic_req_valid !== 1'b1) begin
      miscompares++; $display("FAIL lsb_single got iss=%b req=%b addr=%h want 0 1 00000028", bus.issue_valid, bus.ic_req_valid, bus.ic_req_addr); end
    bus.rs_full = 1'b0;
  endtask

  task automatic test_flush();
    set_dec(6'd18, 5'd1, 5'd0, 5'd5, 32'd5);
    bus.flush_valid = 1'b1;
    bus.flush_pc    = 32'h100;
    tick();
    bus.flush_valid = 1'b0;
    tick();
    bus.ic_resp_valid = 1'b1;
    bus.ic_resp_inst  = 32'h00500093;
    tick();
    bus.ic_resp_valid = 1'b0;
    vectors++; if (bus.issue_valid !== 1'b0 || bus.ic_req_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_drop got iss=%b req=%b want 0 0", bus.issue_valid, bus.ic_req_valid); end
    tick();
    vectors++; if (bus.issue_valid !== 1'b0 || bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h100) begin
      miscompares++; $display("FAIL flush_refetch got iss=%b req=%b addr=%h want 0 1 00000100", bus.issue_valid, bus.ic_req_valid, bus.ic_req_addr); end
    set_dec(6'd15, 5'd2, 5'd1, 5'd0, 32'd0);
    respond(32'h0000a103, 1);
    bus.flush_valid = 1'b1;
    bus.flush_pc    = 32'h200;
    tick();
    bus.flush_valid = 1'b0;
    vectors++; if (bus.issue_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_issue got iss=%b want 0", bus.issue_valid); end
    tick();
    vectors++; if (bus.issue_valid !== 1'b0 || bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h200) begin
      miscompares++; $display("FAIL flush_issue_refetch got iss=%b req=%b addr=%h want 0 1 00000200", bus.issue_valid, bus.ic_req_valid, bus.ic_req_addr); end
  endtask

  task automatic test_jalr_and_reset();
    int reqs;
    bit ok;
    set_dec(6'd12, 5'd0, 5'd1, 5'd0, 32'd0);
    respond(32'h00008067, 1);
    tick();
    vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_pred_taken !== 1'b0 || bus.issue_pc !== 32'h200) begin
      miscompares++; $display("FAIL jalr_issue got v=%b pt=%b pc=%h want 1 0 00000200", bus.issue_valid, bus.issue_pred_taken, bus.issue_pc); end
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ic_req_valid === 1'b1) reqs++;
    end
    vectors++; if (reqs !== 0) begin
      miscompares++; $display("FAIL jalr_stall got %0d requests want 0", reqs); end
    bus.jalr_done_valid = 1'b1;
    bus.jalr_done_pc    = 32'h40;
    tick();
    bus.jalr_done_valid = 1'b0;
    tick();
    vectors++; if (bus.ic_req_valid !== 1'b1 || bus.ic_req_addr !== 32'h40) begin
      miscompares++; $display("FAIL jalr_target got req=%b addr=%h want 1 00000040", bus.ic_req_valid, bus.ic_req_addr); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.ic_req_valid !== 1'b0 || bus.ic_req_addr !== 32'h0 || bus.issue_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_wait got req=%b addr=%h iss=%b want 0 00000000 0", bus.ic_req_valid, bus.ic_req_addr, bus.issue_valid); end
    tick();
    rst_n = 1'b1;
    wait_req(ok);
    vectors++; if (!ok || bus.ic_req_addr !== 32'h0) begin
      miscompares++; $display("FAIL reset_restart got ok=%b addr=%h want 1 00000000", ok, bus.ic_req_addr); end
  endtask

  initial begin
    bus.ic_resp_valid   = 1'b0;
    bus.ic_resp_inst    = '0;
    bus.rob_full        = 1'b0;
    bus.rs_full         = 1'b0;
    bus.lsb_full        = 1'b0;
    bus.jalr_done_valid = 1'b0;
    bus.jalr_done_pc    = '0;
    bus.flush_valid     = 1'b0;
    bus.flush_pc        = '0;
    set_dec(6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    test_reset();
    test_basic();
    test_rdy_freeze();
    test_jal();
    test_branch();
    test_lsb_full();
    test_flush();
    test_jalr_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
